// File: rtl/mac_pkg.sv
// Shared constants, group-state encoding and width helpers for the MAC output path.
// Helpers work on MAXW-bit carriers so they serve any lane width up to MAXW.
package mac_pkg;

  localparam int unsigned COLUMN_DEF = 6;
  localparam int unsigned OW_DEF     = 22;
  localparam int unsigned AW_DEF     = 32;
  localparam int unsigned QW_DEF     = 8;
  localparam int unsigned SHW_DEF    = 5;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned MAXW       = 64;

  typedef enum logic {
    GRP_IDLE,
    GRP_OPEN
  } grp_state_t;

  // Sign-extend the low w bits of v to the full MAXW carrier (1 <= w < MAXW).
  function automatic logic [MAXW-1:0] sign_ext(input logic [MAXW-1:0] v, input int unsigned w);
    logic [MAXW-1:0] hi;
    hi = '1 << w;
    return v[w-1] ? (v | hi) : (v & ~hi);
  endfunction

  // Clamp a signed value to the range representable in w signed bits.
  function automatic logic signed [MAXW-1:0] saturate(input logic signed [MAXW-1:0] v,
                                                      input int unsigned w);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_requant.sv
// One-lane requantizer: round-half-up, arithmetic right shift, saturate to QW bits.
// Purely combinational; rounding is done in AW+1 bits so the bias can never overflow.
module mac_requant
  import mac_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned QW  = QW_DEF,
  parameter int unsigned SHW = SHW_DEF
) (
  input  logic [AW-1:0]  acc,
  input  logic [SHW-1:0] shift,
  output logic [QW-1:0]  q
);

  localparam int unsigned RW = AW + 1;

  logic signed [RW-1:0]   acc_x;
  logic signed [RW-1:0]   rnd;
  logic signed [RW-1:0]   rsum;
  logic signed [RW-1:0]   rsh;
  logic signed [MAXW-1:0] wide;
  logic signed [MAXW-1:0] sat;

  always_comb begin
    acc_x = $signed({acc[AW-1], acc});
    rnd   = '0;
    if (shift != '0) begin
      rnd = $signed(RW'(1) << (shift - 1'b1));
    end
    rsum = acc_x + rnd;
    rsh  = rsum >>> shift;
    wide = $signed(sign_ext(MAXW'(rsh), RW));
    sat  = saturate(wide, QW);
    q    = sat[QW-1:0];
  end

endmodule

// File: rtl/mac_acc.sv
// MAC output accumulator: per-column accumulation over first..last groups, requantization,
// and a 2-entry registered output FIFO.
module mac_acc
  import mac_pkg::*;
#(
  parameter int unsigned COLUMN = COLUMN_DEF,
  parameter int unsigned OW     = OW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned QW     = QW_DEF,
  parameter int unsigned SHW    = SHW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLUMN*OW-1:0] acc_m_data,
  input  logic                 acc_m_first,
  input  logic                 acc_m_last,
  input  logic                 acc_m_valid,
  output logic                 acc_m_ready,
  input  logic [SHW-1:0]       cfg_shift,
  output logic [COLUMN*QW-1:0] acc_s_data,
  output logic                 acc_s_valid,
  input  logic                 acc_s_ready,
  output logic                 err
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  grp_state_t grp_q;
  grp_state_t grp_d;

  logic                 fire;
  logic                 push;
  logic                 pop;
  logic [MAXW-1:0]      ext_lane [COLUMN];
  logic [AW-1:0]        acc_q    [COLUMN];
  logic [AW-1:0]        acc_next [COLUMN];
  logic [COLUMN*QW-1:0] push_data;
  logic [COLUMN*QW-1:0] fifo_mem [FIFO_DEPTH];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  assign acc_m_ready = (count != FULL) & ~rst;
  assign fire        = acc_m_valid & acc_m_ready;
  assign push        = fire & acc_m_last;
  assign pop         = acc_s_valid & acc_s_ready;
  assign acc_s_valid = (count != 2'd0);
  assign acc_s_data  = fifo_mem[rd_ptr];

  // A beat without first while idle restarts the lane sum rather than adding to stale data.
  always_comb begin
    for (int unsigned j = 0; j < COLUMN; j++) begin
      ext_lane[j] = sign_ext(MAXW'(acc_m_data[j*OW +: OW]), OW);
      if (acc_m_first || grp_q == GRP_IDLE) begin
        acc_next[j] = ext_lane[j][AW-1:0];
      end else begin
        acc_next[j] = acc_q[j] + ext_lane[j][AW-1:0];
      end
    end
  end

  always_comb begin
    grp_d = grp_q;
    if (fire) begin
      grp_d = acc_m_last ? GRP_IDLE : GRP_OPEN;
    end
  end

  for (genvar g = 0; g < COLUMN; g++) begin : g_lane
    mac_requant #(
      .AW (AW),
      .QW (QW),
      .SHW(SHW)
    ) u_requant (
      .acc  (acc_next[g]),
      .shift(cfg_shift),
      .q    (push_data[g*QW +: QW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q  <= GRP_IDLE;
      err    <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int unsigned j = 0; j < COLUMN; j++) begin
        acc_q[j] <= '0;
      end
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem[k] <= '0;
      end
    end else begin
      grp_q <= grp_d;
      if (fire && !acc_m_first && grp_q == GRP_IDLE) begin
        err <= 1'b1;
      end
      if (fire) begin
        for (int unsigned j = 0; j < COLUMN; j++) begin
          acc_q[j] <= acc_next[j];
        end
      end
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// Scenario bench for mac_acc: a behavioural model queues expected output beats as
// stimulus is driven; each scenario pops and compares when the DUT presents a result.
module tb_mac_acc;

  localparam int unsigned COLUMN = 6;
  localparam int unsigned OW     = 22;
  localparam int unsigned AW     = 32;
  localparam int unsigned QW     = 8;
  localparam int unsigned SHW    = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [COLUMN*OW-1:0] acc_m_data = '0;
  logic                 acc_m_first = 1'b0;
  logic                 acc_m_last = 1'b0;
  logic                 acc_m_valid = 1'b0;
  logic                 acc_m_ready;
  logic [SHW-1:0]       cfg_shift = '0;
  logic [COLUMN*QW-1:0] acc_s_data;
  logic                 acc_s_valid;
  logic                 acc_s_ready = 1'b1;
  logic                 err;

  int checks = 0;
  int passed = 0;

  longint               ln    [COLUMN];
  longint               m_acc [COLUMN];
  bit                   m_open = 1'b0;
  bit                   m_err  = 1'b0;
  logic [COLUMN*QW-1:0] sb [$];

  mac_acc #(
    .COLUMN(COLUMN),
    .OW    (OW),
    .AW    (AW),
    .QW    (QW),
    .SHW   (SHW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_m_data (acc_m_data),
    .acc_m_first(acc_m_first),
    .acc_m_last (acc_m_last),
    .acc_m_valid(acc_m_valid),
    .acc_m_ready(acc_m_ready),
    .cfg_shift  (cfg_shift),
    .acc_s_data (acc_s_data),
    .acc_s_valid(acc_s_valid),
    .acc_s_ready(acc_s_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  task automatic model_reset();
    m_open = 1'b0;
    m_err  = 1'b0;
    for (int j = 0; j < COLUMN; j++) m_acc[j] = 0;
    sb.delete();
  endtask

  task automatic model_beat(input bit first, input bit last, input int sh);
    logic [COLUMN*QW-1:0] exp;
    longint r;
    longint q;
    if (!first && !m_open) m_err = 1'b1;
    for (int j = 0; j < COLUMN; j++) begin
      if (first || !m_open) m_acc[j] = ln[j];
      else                  m_acc[j] = wrap32(m_acc[j] + ln[j]);
    end
    m_open = !last;
    if (last) begin
      exp = '0;
      for (int j = 0; j < COLUMN; j++) begin
        r = m_acc[j] + ((sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1)));
        q = r >>> sh;
        if (q > 127)       q = 127;
        else if (q < -128) q = -128;
        exp[j*QW +: QW] = q[7:0];
      end
      sb.push_back(exp);
    end
  endtask

  task automatic drive_lanes();
    for (int j = 0; j < COLUMN; j++) begin
      acc_m_data[j*OW +: OW] = ln[j][OW-1:0];
    end
  endtask

  task automatic send_beat(input bit first, input bit last, input int sh);
    int n;
    drive_lanes();
    acc_m_first = first;
    acc_m_last  = last;
    cfg_shift   = sh[SHW-1:0];
    acc_m_valid = 1'b1;
    n = 0;
    while (!acc_m_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!acc_m_ready) begin
      $display("FAIL send_ready: acc_m_ready=%b required 1 within 50 cycles", acc_m_ready);
      acc_m_valid = 1'b0;
    end else begin
      passed++;
      model_beat(first, last, sh);
      @(posedge clk); #1;
      acc_m_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!acc_s_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (acc_m_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", acc_m_ready);
    else passed++;
    checks++;
    if (acc_s_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", acc_s_valid);
    else passed++;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) $display("FAIL rst_err: got %b required 0", err);
    else passed++;
    checks++;
    if (acc_m_ready !== 1'b1) $display("FAIL rst_ready_after: got %b required 1", acc_m_ready);
    else passed++;
    checks++;
    if (acc_s_valid !== 1'b0) $display("FAIL rst_valid_after: got %b required 0", acc_s_valid);
    else passed++;
  endtask

  task automatic test_single();
    int lat;
    logic [COLUMN*QW-1:0] exp;
    ln = '{default: 0};
    ln[0] = 5;
    ln[5] = -3;
    send_beat(1'b1, 1'b1, 0);
    wait_out(lat);
    checks++;
    if (lat != 0) $display("FAIL single_latency: got %0d extra cycles required 0", lat);
    else passed++;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (!acc_s_valid || acc_s_data !== exp)
      $display("FAIL single_data: got %h (valid %b) required %h", acc_s_data, acc_s_valid, exp);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL single_err: got %b required 0", err);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (acc_s_valid !== 1'b0) $display("FAIL single_drain: valid %b required 0", acc_s_valid);
    else passed++;
  endtask

  task automatic test_multibeat();
    int lat;
    logic [COLUMN*QW-1:0] exp;
    for (int rep = 0; rep < 2; rep++) begin
      ln = '{default: 0};
      ln[0] = (rep == 0) ? 100 : -2;
      send_beat(1'b1, 1'b0, 2);
      send_beat(1'b0, 1'b0, 2);
      send_beat(1'b0, 1'b1, 2);
      wait_out(lat);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      checks++;
      if (!acc_s_valid || acc_s_data !== exp)
        $display("FAIL multibeat_%0d: got %h (valid %b) required %h", rep, acc_s_data, acc_s_valid, exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [COLUMN*QW-1:0] exp;
    ln = '{default: 0};
    ln[0] = 1000;
    ln[1] = -1000;
    send_beat(1'b1, 1'b1, 0);
    wait_out(lat);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (!acc_s_valid || acc_s_data !== exp)
      $display("FAIL saturate: got %h (valid %b) required %h", acc_s_data, acc_s_valid, exp);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [COLUMN*QW-1:0] exp;
    logic [COLUMN*QW-1:0] head;
    bit will_acc;
    int got;
    acc_s_ready = 1'b0;
    ln = '{default: 0};
    ln[0] = 1;
    send_beat(1'b1, 1'b1, 0);
    ln[0] = 2;
    send_beat(1'b1, 1'b1, 0);
    checks++;
    if (acc_m_ready !== 1'b0) $display("FAIL bp_full_ready: got %b required 0", acc_m_ready);
    else passed++;
    ln[0] = 3;
    drive_lanes();
    acc_m_first = 1'b1;
    acc_m_last  = 1'b1;
    cfg_shift   = '0;
    acc_m_valid = 1'b1;
    model_beat(1'b1, 1'b1, 0);
    head = sb[0];
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (acc_m_ready !== 1'b0) $display("FAIL bp_held_ready: got %b required 0", acc_m_ready);
    else passed++;
    checks++;
    if (acc_s_data !== head) $display("FAIL bp_stable: got %h required %h", acc_s_data, head);
    else passed++;
    acc_s_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      will_acc = acc_m_valid & acc_m_ready;
      if (acc_s_valid) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        checks++;
        if (acc_s_data !== exp)
          $display("FAIL bp_order_%0d: got %h required %h", got, acc_s_data, exp);
        else passed++;
        got++;
      end
      @(posedge clk); #1;
      if (will_acc) acc_m_valid = 1'b0;
    end
    checks++;
    if (got != 3) $display("FAIL bp_count: got %0d outputs required 3", got);
    else passed++;
    checks++;
    if (acc_s_valid !== 1'b0 || acc_m_valid !== 1'b0)
      $display("FAIL bp_drain: s_valid %b m_valid %b required 0 0", acc_s_valid, acc_m_valid);
    else passed++;
    acc_m_valid = 1'b0;
  endtask

  task automatic test_framing_err();
    int lat;
    logic [COLUMN*QW-1:0] exp;
    ln = '{default: 0};
    ln[0] = 7;
    send_beat(1'b0, 1'b1, 0);
    wait_out(lat);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (!acc_s_valid || acc_s_data !== exp)
      $display("FAIL err_data: got %h (valid %b) required %h", acc_s_data, acc_s_valid, exp);
    else passed++;
    checks++;
    if (err !== m_err) $display("FAIL err_set: got %b required %b", err, m_err);
    else passed++;
    @(posedge clk); #1;
    ln[0] = 9;
    send_beat(1'b1, 1'b1, 0);
    wait_out(lat);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (!acc_s_valid || acc_s_data !== exp)
      $display("FAIL err_next_data: got %h (valid %b) required %h", acc_s_data, acc_s_valid, exp);
    else passed++;
    checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b required 1", err);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [COLUMN*QW-1:0] exp;
    ln = '{default: 0};
    ln[0] = 50;
    send_beat(1'b1, 1'b0, 0);
    rst = 1'b1;
    ln[0] = 99;
    drive_lanes();
    acc_m_first = 1'b1;
    acc_m_last  = 1'b1;
    acc_m_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (acc_s_valid !== 1'b0 || acc_m_ready !== 1'b0)
      $display("FAIL midrst_hold: s_valid %b m_ready %b required 0 0", acc_s_valid, acc_m_ready);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m_valid = 1'b0;
    model_reset();
    checks++;
    if (err !== 1'b0) $display("FAIL midrst_err: got %b required 0", err);
    else passed++;
    ln[0] = 4;
    send_beat(1'b1, 1'b1, 0);
    wait_out(lat);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (!acc_s_valid || acc_s_data !== exp)
      $display("FAIL midrst_data: got %h (valid %b) required %h", acc_s_data, acc_s_valid, exp);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (acc_s_valid !== 1'b0) $display("FAIL midrst_extra: valid %b required 0", acc_s_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int nb;
    int sh;
    logic [COLUMN*QW-1:0] exp;
    for (int g = 0; g < 6; g++) begin
      nb = int'($urandom_range(3, 1));
      sh = int'($urandom_range(20, 0));
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < COLUMN; j++) begin
          ln[j] = longint'($urandom_range(4194303, 0)) - 64'sd2097152;
        end
        send_beat(b == 0, b == nb - 1, sh);
      end
      wait_out(lat);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      checks++;
      if (!acc_s_valid || acc_s_data !== exp)
        $display("FAIL b2b_%0d: got %h (valid %b) required %h shift %0d", g, acc_s_data, acc_s_valid, exp, sh);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multibeat();
    test_saturate();
    test_backpressure();
    test_framing_err();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
